// File: rtl/yarp_rf_wb_sched_if.sv
// Writeback request bus: NUM_REQ requesters offering (rd, data) to the
// register-file write scheduler over a per-requester valid/ready handshake.
interface yarp_rf_wb_sched_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [NUM_REQ*5-1:0]  req_rd_i;
    logic [NUM_REQ*32-1:0] req_data_i;

    modport master (
        output req_valid_i,
        output req_rd_i,
        output req_data_i,
        input  req_ready_o
    );

    modport slave (
        input  req_valid_i,
        input  req_rd_i,
        input  req_data_i,
        output req_ready_o
    );
endinterface

// File: rtl/yarp_rf_wb_sched.sv
// Writeback scheduler: arbitrates the single regfile write port and tracks
// pending destinations for RAW detection. Define YARP_WB_RR_EN for round-robin.
module yarp_rf_wb_sched #(
    parameter int NUM_REQ = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    yarp_rf_wb_sched_if.slave req_if,
    input  logic              issue_i,
    input  logic [4:0]        issue_rd_i,
    input  logic [4:0]        rs1_addr_i,
    output logic              rs1_busy_o,
    input  logic [4:0]        rs2_addr_i,
    output logic              rs2_busy_o,
    output logic              wr_en_o,
    output logic [4:0]        rd_addr_o,
    output logic [31:0]       wr_data_o
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic             grant_vld;
    logic [IDX_W-1:0] grant_idx;
    logic [4:0]       sel_rd;
    logic [31:0]      sel_data;

    logic             wr_en_q,   wr_en_d;
    logic [4:0]       rd_addr_q, rd_addr_d;
    logic [31:0]      wr_data_q, wr_data_d;
    logic [31:0]      sb_q,      sb_d;

`ifdef YARP_WB_RR_EN
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    // Scan downward so the valid requester closest to rr_ptr is the last write.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_if.req_valid_i[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) begin
            rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_if.req_valid_i[k]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'(k);
            end
        end
    end
`endif

    // The regfile never stalls, so any valid requester is granted immediately.
    always_comb begin
        req_if.req_ready_o = '0;
        if (grant_vld) begin
            req_if.req_ready_o = NUM_REQ'(1) << grant_idx;
        end
    end

    assign sel_rd   = req_if.req_rd_i[int'(grant_idx)*5 +: 5];
    assign sel_data = req_if.req_data_i[int'(grant_idx)*32 +: 32];

    always_comb begin
        wr_en_d   = grant_vld && (sel_rd != 5'd0);
        rd_addr_d = grant_vld ? sel_rd   : rd_addr_q;
        wr_data_d = grant_vld ? sel_data : wr_data_q;
    end

    // Set after clear: a newer producer of the same register keeps it busy.
    always_comb begin
        sb_d = sb_q;
        if (wr_en_q) begin
            sb_d[rd_addr_q] = 1'b0;
        end
        if (issue_i) begin
            sb_d[issue_rd_i] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_data_q <= '0;
            sb_q      <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            rd_addr_q <= rd_addr_d;
            wr_data_q <= wr_data_d;
            sb_q      <= sb_d;
        end
    end

    assign wr_en_o    = wr_en_q;
    assign rd_addr_o  = rd_addr_q;
    assign wr_data_o  = wr_data_q;
    assign rs1_busy_o = sb_q[rs1_addr_i];
    assign rs2_busy_o = sb_q[rs2_addr_i];
endmodule
